// File: rtl/dcasic_pkg.sv
`timescale 1ns/1ps
// dcasic shared types for the DVP camera receive path.
package dcasic_pkg;

    localparam int FRAME_W_DEF = 640;
    localparam int FRAME_H_DEF = 480;
    localparam int PXL_W_DEF   = 16;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VS,
        LINE,
        CAPT,
        DROP
    } dvp_st_e;

    typedef struct packed {
        logic                 sof;
        logic                 eol;
        logic [PXL_W_DEF-1:0] data;
    } pxl_beat_t;

endpackage

// File: rtl/dvp_rx_capture_if.sv
`timescale 1ns/1ps
// Pixel stream towards the frame-buffer/DMA path.
interface dvp_rx_capture_if #(
    parameter int PXL_W = 16
);
    logic [PXL_W-1:0] pxl_data_o;
    logic             pxl_sof_o;
    logic             pxl_eol_o;
    logic             pxl_vld_o;
    logic             pxl_rdy_i;

    modport master (
        output pxl_data_o, pxl_sof_o, pxl_eol_o, pxl_vld_o,
        input  pxl_rdy_i
    );

    modport slave (
        input  pxl_data_o, pxl_sof_o, pxl_eol_o, pxl_vld_o,
        output pxl_rdy_i
    );
endinterface

// File: rtl/pxl_sfifo.sv
`timescale 1ns/1ps
// Synchronous pixel-beat FIFO; a pop on full frees the slot for a same-cycle push.
module pxl_sfifo
    import dcasic_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      sys_clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  pxl_beat_t wdata_i,
    input  logic      pop_i,
    output pxl_beat_t rdata_o,
    output logic      full_o,
    output logic      empty_o
);
    localparam int AW = $clog2(DEPTH);

    pxl_beat_t   mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    logic        do_push;
    logic        do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    assign rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
        end
    end
endmodule

// File: rtl/dvp_rx_capture.sv
`timescale 1ns/1ps
// DVP camera receive front-end: XCLK generation, pin sync, RGB565 assembly.
module dvp_rx_capture
    import dcasic_pkg::*;
#(
    parameter int DVP_DATA_W = 8,
    parameter int PXL_W      = 16,
    parameter int FRAME_W    = FRAME_W_DEF,
    parameter int FRAME_H    = FRAME_H_DEF,
    parameter int XCLK_DIV   = 6,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  cap_en_i,
    output logic                  dvp_xclk_o,
    input  logic                  dvp_pclk_i,
    input  logic                  dvp_vsync_i,
    input  logic                  dvp_href_i,
    input  logic [DVP_DATA_W-1:0] dvp_d_i,
    dvp_rx_capture_if.master      pxl,
    output logic                  ovf_o,
    output logic                  fmt_err_o,
    output logic [15:0]           frame_cnt_o
);
    localparam int XW  = $clog2(XCLK_DIV);
    localparam int PCW = $clog2(FRAME_W + 1);
    localparam int LCW = $clog2(FRAME_H + 1);

    logic [XW-1:0] xcnt_q, xcnt_d;
    logic          xclk_q;

    assign xcnt_d = (xcnt_q == XW'(XCLK_DIV - 1)) ? '0 : xcnt_q + 1'b1;

    // xclk_q mirrors (xcnt_q < half) but is forced low in reset
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            xcnt_q <= '0;
            xclk_q <= 1'b0;
        end else begin
            xcnt_q <= xcnt_d;
            xclk_q <= (xcnt_d < XW'(XCLK_DIV / 2));
        end
    end

    assign dvp_xclk_o = xclk_q;

    logic [2:0]            pclk_q;
    logic [1:0]            vs_q;
    logic [1:0]            hr_q;
    logic [DVP_DATA_W-1:0] d1_q, d2_q;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            pclk_q <= '0;
            vs_q   <= '0;
            hr_q   <= '0;
            d1_q   <= '0;
            d2_q   <= '0;
        end else begin
            pclk_q <= {pclk_q[1:0], dvp_pclk_i};
            vs_q   <= {vs_q[0], dvp_vsync_i};
            hr_q   <= {hr_q[0], dvp_href_i};
            d1_q   <= dvp_d_i;
            d2_q   <= d1_q;
        end
    end

    logic rise, vs_s2, hr_s2;
    logic vs_prev_q, vs_rise, vs_fall;

    assign rise    = pclk_q[1] & ~pclk_q[2];
    assign vs_s2   = vs_q[1];
    assign hr_s2   = hr_q[1];
    assign vs_rise = ~vs_prev_q & vs_s2;
    assign vs_fall = vs_prev_q & ~vs_s2;

    dvp_st_e               state_q;
    logic [DVP_DATA_W-1:0] hi_q;
    logic                  byte_odd_q;
    logic [PCW-1:0]        pix_cnt_q;
    logic [LCW-1:0]        line_cnt_q;
    logic                  sof_arm_q;
    logic                  push_q;
    pxl_beat_t             beat_q;
    logic                  ovf_q, fmt_err_q;
    logic [15:0]           frame_cnt_q;
    logic                  fifo_full, fifo_empty, pop, push_ok;
    pxl_beat_t             rd_beat;

    assign pop     = pxl.pxl_vld_o && pxl.pxl_rdy_i;
    assign push_ok = !fifo_full || pop;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vs_prev_q   <= 1'b0;
            hi_q        <= '0;
            byte_odd_q  <= 1'b0;
            pix_cnt_q   <= '0;
            line_cnt_q  <= '0;
            sof_arm_q   <= 1'b0;
            push_q      <= 1'b0;
            beat_q      <= '0;
            ovf_q       <= 1'b0;
            fmt_err_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            push_q <= 1'b0;
            if (rise) vs_prev_q <= vs_s2;
            unique case (state_q)
                IDLE: if (cap_en_i) state_q <= WAIT_VS;
                WAIT_VS: begin
                    if (!cap_en_i) begin
                        state_q <= IDLE;
                    end else if (rise && vs_fall) begin
                        line_cnt_q <= '0;
                        pix_cnt_q  <= '0;
                        byte_odd_q <= 1'b0;
                        sof_arm_q  <= 1'b1;
                        state_q    <= LINE;
                    end
                end
                LINE: if (rise) begin
                    if (hr_s2) begin
                        hi_q       <= d2_q;
                        byte_odd_q <= 1'b1;
                        pix_cnt_q  <= '0;
                        state_q    <= CAPT;
                    end else if (vs_rise) begin
                        if (line_cnt_q == LCW'(FRAME_H))
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                        else
                            fmt_err_q <= 1'b1;
                        state_q <= cap_en_i ? WAIT_VS : IDLE;
                    end
                end
                CAPT: if (rise) begin
                    if (hr_s2 && !byte_odd_q) begin
                        hi_q       <= d2_q;
                        byte_odd_q <= 1'b1;
                    end else if (hr_s2) begin
                        push_q     <= 1'b1;
                        beat_q     <= {sof_arm_q,
                                       pix_cnt_q == PCW'(FRAME_W - 1),
                                       hi_q, d2_q};
                        sof_arm_q  <= 1'b0;
                        pix_cnt_q  <= pix_cnt_q + 1'b1;
                        byte_odd_q <= 1'b0;
                    end else begin
                        if (byte_odd_q || pix_cnt_q != PCW'(FRAME_W))
                            fmt_err_q <= 1'b1;
                        line_cnt_q <= line_cnt_q + 1'b1;
                        byte_odd_q <= 1'b0;
                        state_q    <= LINE;
                    end
                end
                DROP: if (rise && vs_rise)
                    state_q <= cap_en_i ? WAIT_VS : IDLE;
                default: state_q <= IDLE;
            endcase
            // a rejected write kills the rest of the frame
            if (push_q && !push_ok) begin
                state_q <= DROP;
                ovf_q   <= 1'b1;
            end
        end
    end

    pxl_sfifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .push_i  (push_q),
        .wdata_i (beat_q),
        .pop_i   (pop),
        .rdata_o (rd_beat),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign pxl.pxl_vld_o  = !fifo_empty;
    assign pxl.pxl_data_o = PXL_W'(rd_beat.data);
    assign pxl.pxl_sof_o  = rd_beat.sof;
    assign pxl.pxl_eol_o  = rd_beat.eol;
    assign ovf_o          = ovf_q;
    assign fmt_err_o      = fmt_err_q;
    assign frame_cnt_o    = frame_cnt_q;
endmodule

// File: tb/tb_dvp_rx_capture.sv
`timescale 1ns/1ps
// Directed bench for dvp_rx_capture on reduced 16x4 frames.
module tb_dvp_rx_capture;
    import dcasic_pkg::*;

    localparam int FW = 16;
    localparam int FH = 4;

    logic        sys_clk = 1'b0;
    logic        rst_n, cap_en, xclk, pclk, vsync, href;
    logic [7:0]  d;
    logic        ovf, fmt_err;
    logic [15:0] fcnt;

    int          n_vec = 0;
    int          n_err = 0;
    int          rdy_mode = 0;
    logic        sof_pend;
    pxl_beat_t   exp_q[$];
    pxl_beat_t   recv_q[$];

    always #1 sys_clk = ~sys_clk;

    dvp_rx_capture_if #(.PXL_W(16)) pxl ();

    dvp_rx_capture #(
        .FRAME_W (FW),
        .FRAME_H (FH)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .cap_en_i    (cap_en),
        .dvp_xclk_o  (xclk),
        .dvp_pclk_i  (pclk),
        .dvp_vsync_i (vsync),
        .dvp_href_i  (href),
        .dvp_d_i     (d),
        .pxl         (pxl),
        .ovf_o       (ovf),
        .fmt_err_o   (fmt_err),
        .frame_cnt_o (fcnt)
    );

    // consumer: pick ready, then record the beat that the next edge transfers
    always @(negedge sys_clk) begin
        if (rdy_mode == 0) pxl.pxl_rdy_i = 1'b1;
        else if (rdy_mode == 1) pxl.pxl_rdy_i = 1'($urandom_range(0, 1));
        else pxl.pxl_rdy_i = 1'b0;
        if (rst_n && pxl.pxl_vld_o && pxl.pxl_rdy_i)
            recv_q.push_back({pxl.pxl_sof_o, pxl.pxl_eol_o, pxl.pxl_data_o});
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    function automatic logic [7:0] byte_of(input int pat, input int k);
        if (pat == 0) return 8'(k % 32);
        if (pat == 1) return 8'((k * 13 + 5) % 256);
        return 8'((k * 7 + pat) % 256);
    endfunction

    task automatic pclk_cycle(input logic vs, input logic hr, input logic [7:0] b);
        @(negedge sys_clk);
        vsync = vs;
        href  = hr;
        d     = b;
        pclk  = 1'b0;
        repeat (3) @(negedge sys_clk);
        pclk = 1'b1;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic vs_pulse();
        repeat (3) pclk_cycle(1'b1, 1'b0, 8'h00);
        repeat (2) pclk_cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_line(input int nb, input int pat, inout int k, input bit model);
        logic [7:0] hi, b;
        hi = '0;
        for (int i = 0; i < nb; i++) begin
            b = byte_of(pat, k);
            k++;
            pclk_cycle(1'b0, 1'b1, b);
            if (i % 2 == 0) begin
                hi = b;
            end else if (model) begin
                exp_q.push_back({sof_pend, (i / 2 == FW - 1), hi, b});
                sof_pend = 1'b0;
            end
        end
        repeat (2) pclk_cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_frame(input bit open, input int pat, input int odd_line, input bit model);
        int k;
        k = 0;
        if (open) vs_pulse();
        sof_pend = 1'b1;
        for (int l = 0; l < FH; l++)
            send_line((l == odd_line) ? 2 * FW - 1 : 2 * FW, pat, k, model);
        vs_pulse();
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 3000 && recv_q.size() < exp_q.size(); t++)
            @(negedge sys_clk);
        repeat (20) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        repeat (4) @(negedge sys_clk);
        n_vec++; if (xclk !== 1'b0) begin n_err++; $display("FAIL reset_xclk got %b want 0", xclk); end
        n_vec++; if (pxl.pxl_vld_o !== 1'b0) begin n_err++; $display("FAIL reset_vld got %b want 0", pxl.pxl_vld_o); end
        n_vec++; if (pxl.pxl_data_o !== 16'h0) begin n_err++; $display("FAIL reset_data got %h want 0", pxl.pxl_data_o); end
        n_vec++; if ({pxl.pxl_sof_o, pxl.pxl_eol_o} !== 2'b00) begin n_err++; $display("FAIL reset_marks got %b want 00", {pxl.pxl_sof_o, pxl.pxl_eol_o}); end
        n_vec++; if ({ovf, fmt_err} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b want 00", {ovf, fmt_err}); end
        n_vec++; if (fcnt !== 16'h0) begin n_err++; $display("FAIL reset_fcnt got %0d want 0", fcnt); end
        rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        n_vec++; if (pxl.pxl_vld_o !== 1'b0) begin n_err++; $display("FAIL idle_vld got %b want 0", pxl.pxl_vld_o); end
    endtask

    task automatic test_xclk();
        logic prev;
        int   hi_n, lo_n;
        time  t0, t1;
        @(negedge sys_clk);
        prev = xclk;
        for (int t = 0; t < 20; t++) begin
            @(negedge sys_clk);
            if (xclk && !prev) break;
            prev = xclk;
        end
        t0 = $time;
        hi_n = 0;
        lo_n = 0;
        while (xclk && hi_n < 20) begin hi_n++; @(negedge sys_clk); end
        while (!xclk && lo_n < 20) begin lo_n++; @(negedge sys_clk); end
        t1 = $time;
        n_vec++; if (hi_n !== 3) begin n_err++; $display("FAIL xclk_high got %0d want 3", hi_n); end
        n_vec++; if (lo_n !== 3) begin n_err++; $display("FAIL xclk_low got %0d want 3", lo_n); end
        n_vec++; if (t1 - t0 !== 12) begin n_err++; $display("FAIL xclk_period got %0t want 12", t1 - t0); end
    endtask

    task automatic test_frame();
        exp_q.delete();
        recv_q.delete();
        rdy_mode = 0;
        cap_en = 1'b1;
        send_frame(1'b1, 0, -1, 1'b1);
        wait_drain();
        n_vec++; if (recv_q.size() !== FW * FH) begin n_err++; $display("FAIL frame_len got %0d want %0d", recv_q.size(), FW * FH); end
        for (int i = 0; i < exp_q.size() && i < recv_q.size(); i++) begin
            n_vec++; if (recv_q[i] !== exp_q[i]) begin n_err++; $display("FAIL frame_beat%0d got %h want %h", i, recv_q[i], exp_q[i]); end
        end
        n_vec++; if (recv_q[0] !== {1'b1, 1'b0, 16'h0001}) begin n_err++; $display("FAIL frame_first got %h want 20001", recv_q[0]); end
        n_vec++; if (recv_q[FW-1] !== {1'b0, 1'b1, 16'h1E1F}) begin n_err++; $display("FAIL frame_eol got %h want 11e1f", recv_q[FW-1]); end
        n_vec++; if (fcnt !== 16'd1) begin n_err++; $display("FAIL frame_fcnt got %0d want 1", fcnt); end
        n_vec++; if ({ovf, fmt_err} !== 2'b00) begin n_err++; $display("FAIL frame_flags got %b want 00", {ovf, fmt_err}); end
    endtask

    task automatic test_backpressure();
        exp_q.delete();
        recv_q.delete();
        rdy_mode = 1;
        send_frame(1'b0, 1, -1, 1'b1);
        wait_drain();
        rdy_mode = 0;
        n_vec++; if (recv_q.size() !== FW * FH) begin n_err++; $display("FAIL bp_len got %0d want %0d", recv_q.size(), FW * FH); end
        for (int i = 0; i < exp_q.size() && i < recv_q.size(); i++) begin
            n_vec++; if (recv_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_beat%0d got %h want %h", i, recv_q[i], exp_q[i]); end
        end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL bp_ovf got %b want 0", ovf); end
        n_vec++; if (fcnt !== 16'd2) begin n_err++; $display("FAIL bp_fcnt got %0d want 2", fcnt); end
    endtask

    task automatic test_fmt_err();
        exp_q.delete();
        recv_q.delete();
        send_frame(1'b0, 2, 1, 1'b1);
        wait_drain();
        n_vec++; if (recv_q.size() !== FW * FH - 1) begin n_err++; $display("FAIL fmt_len got %0d want %0d", recv_q.size(), FW * FH - 1); end
        for (int i = 0; i < exp_q.size() && i < recv_q.size(); i++) begin
            n_vec++; if (recv_q[i] !== exp_q[i]) begin n_err++; $display("FAIL fmt_beat%0d got %h want %h", i, recv_q[i], exp_q[i]); end
        end
        n_vec++; if (fmt_err !== 1'b1) begin n_err++; $display("FAIL fmt_flag got %b want 1", fmt_err); end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL fmt_ovf got %b want 0", ovf); end
        n_vec++; if (fcnt !== 16'd3) begin n_err++; $display("FAIL fmt_fcnt got %0d want 3", fcnt); end
    endtask

    task automatic test_overflow();
        exp_q.delete();
        recv_q.delete();
        rdy_mode = 2;
        send_frame(1'b0, 3, -1, 1'b1);
        while (exp_q.size() > 8) void'(exp_q.pop_back());
        n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", ovf); end
        n_vec++; if (fcnt !== 16'd3) begin n_err++; $display("FAIL ovf_fcnt got %0d want 3", fcnt); end
        n_vec++; if (recv_q.size() !== 0) begin n_err++; $display("FAIL ovf_stall got %0d want 0", recv_q.size()); end
        n_vec++; if ({pxl.pxl_vld_o, pxl.pxl_sof_o, pxl.pxl_data_o} !== {2'b11, 16'h030A}) begin
            n_err++; $display("FAIL ovf_hold got %b/%b/%h want 1/1/030a", pxl.pxl_vld_o, pxl.pxl_sof_o, pxl.pxl_data_o);
        end
        rdy_mode = 0;
        send_frame(1'b0, 3, -1, 1'b1);
        wait_drain();
        n_vec++; if (recv_q.size() !== 8 + FW * FH) begin n_err++; $display("FAIL ovf_len got %0d want %0d", recv_q.size(), 8 + FW * FH); end
        for (int i = 0; i < exp_q.size() && i < recv_q.size(); i++) begin
            n_vec++; if (recv_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ovf_beat%0d got %h want %h", i, recv_q[i], exp_q[i]); end
        end
        n_vec++; if (recv_q[8].sof !== 1'b1) begin n_err++; $display("FAIL ovf_resume_sof got %b want 1", recv_q[8].sof); end
        n_vec++; if (fcnt !== 16'd4) begin n_err++; $display("FAIL ovf_fcnt_next got %0d want 4", fcnt); end
    endtask

    task automatic test_reset_midline();
        int k;
        exp_q.delete();
        recv_q.delete();
        rdy_mode = 0;
        k = 0;
        for (int i = 0; i < 10; i++) pclk_cycle(1'b0, 1'b1, byte_of(0, i));
        @(negedge sys_clk);
        rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        n_vec++; if ({xclk, pxl.pxl_vld_o, ovf, fmt_err} !== 4'b0000) begin
            n_err++; $display("FAIL mid_rst_bits got %b want 0000", {xclk, pxl.pxl_vld_o, ovf, fmt_err});
        end
        n_vec++; if (fcnt !== 16'h0) begin n_err++; $display("FAIL mid_rst_fcnt got %0d want 0", fcnt); end
        n_vec++; if (pxl.pxl_data_o !== 16'h0) begin n_err++; $display("FAIL mid_rst_data got %h want 0", pxl.pxl_data_o); end
        rst_n = 1'b1;
        recv_q.delete();
        for (int i = 0; i < 10; i++) pclk_cycle(1'b0, 1'b1, 8'hA5);
        repeat (2) pclk_cycle(1'b0, 1'b0, 8'h00);
        send_line(2 * FW, 0, k, 1'b0);
        repeat (20) @(negedge sys_clk);
        n_vec++; if (recv_q.size() !== 0) begin n_err++; $display("FAIL mid_quiet got %0d want 0", recv_q.size()); end
        send_frame(1'b1, 4, -1, 1'b1);
        wait_drain();
        n_vec++; if (recv_q.size() !== FW * FH) begin n_err++; $display("FAIL mid_len got %0d want %0d", recv_q.size(), FW * FH); end
        for (int i = 0; i < exp_q.size() && i < recv_q.size(); i++) begin
            n_vec++; if (recv_q[i] !== exp_q[i]) begin n_err++; $display("FAIL mid_beat%0d got %h want %h", i, recv_q[i], exp_q[i]); end
        end
        n_vec++; if (recv_q[0].sof !== 1'b1) begin n_err++; $display("FAIL mid_sof got %b want 1", recv_q[0].sof); end
        n_vec++; if (fcnt !== 16'd1) begin n_err++; $display("FAIL mid_fcnt got %0d want 1", fcnt); end
        n_vec++; if ({ovf, fmt_err} !== 2'b00) begin n_err++; $display("FAIL mid_flags got %b want 00", {ovf, fmt_err}); end
    endtask

    initial begin
        rst_n  = 1'b0;
        cap_en = 1'b0;
        pclk   = 1'b0;
        vsync  = 1'b0;
        href   = 1'b0;
        d      = 8'h00;
        test_reset();
        test_xclk();
        test_frame();
        test_backpressure();
        test_fmt_err();
        test_overflow();
        test_reset_midline();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
